// File: rtl/arb_mux_stage_pkg.sv
// Types and helpers for the round-robin arbitration stage.
package arb_mux_stage_pkg;

    typedef enum logic {
        LOCK_OPEN = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_t;

    // Modulo-n increment by explicit compare, so n need not be a power of 2.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/common_pkg.sv
// Shared constants for the NoC switch datapath blocks.
package common_pkg;

    localparam int DEFAULT_D_W = 32;
    localparam int ARB_MAX_N   = 16;

endpackage

// File: rtl/arb_mux_stage_if.sv
// Handshake bundle between N competing input queues, the arbitration stage and the output link.
interface arb_mux_stage_if #(
    parameter int N = 6,
    parameter int W = common_pkg::DEFAULT_D_W
);
    localparam int L = $clog2(N);

    logic [N-1:0]        i_valid;
    logic [N-1:0]        i_ready;
    logic [N-1:0][W-1:0] i_data;
    logic [N-1:0]        i_last;
    logic                o_valid;
    logic                o_ready;
    logic [W-1:0]        o_data;
    logic                o_last;
    logic [L-1:0]        o_grant;

    modport master (
        output i_valid, i_data, i_last, o_ready,
        input  i_ready, o_valid, o_data, o_last, o_grant
    );

    modport slave (
        input  i_valid, i_data, i_last, o_ready,
        output i_ready, o_valid, o_data, o_last, o_grant
    );
endinterface

// File: rtl/mux.sv
// Generic N:1 one-of-N data multiplexer; select values at or above N yield zero.
module mux #(
    parameter int N = 2,
    parameter int W = 8
) (
    input  logic [N-1:0][W-1:0] d,
    input  logic [$clog2(N)-1:0] s,
    output logic [W-1:0]         y
);

    always_comb begin
        y = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(s) == i) y = d[i];
        end
    end

endmodule

// File: rtl/arb_mux_stage.sv
// Registered N:1 round-robin arbitration stage feeding a NoC switch output link.
// Define ARB_MUX_STAGE_LAST_LOCK_EN to hold the grant on one input until its i_last beat.
module arb_mux_stage
    import common_pkg::*;
    import arb_mux_stage_pkg::*;
#(
    parameter int N = 6,
    parameter int W = DEFAULT_D_W
) (
    input  logic           clk,
    input  logic           rst_n,
    arb_mux_stage_if.slave bus
);
    localparam int L = $clog2(N);

    if (N < 2 || N > ARB_MAX_N) begin : g_bad_n
        $error("arb_mux_stage: N=%0d outside 2..%0d", N, ARB_MAX_N);
    end

    logic         r_valid;
    logic [W-1:0] r_data;
    logic         r_last;
    logic [L-1:0] r_grant;
    logic [L-1:0] r_ptr;
`ifdef ARB_MUX_STAGE_LAST_LOCK_EN
    lock_state_t  r_lock;
    logic [L-1:0] r_lock_idx;
`endif

    logic         w_load;
    logic         w_any;
    logic         w_xfer;
    logic [L-1:0] w_winner;
    logic [W-1:0] w_mux_y;

    assign w_load = ~r_valid | bus.o_ready;
    // Gating with rst_n keeps every input unready while the stage is held in reset.
    assign w_xfer = rst_n & w_load & w_any;

    always_comb begin
        int idx;
        idx      = 0;
        w_any    = 1'b0;
        w_winner = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!w_any && bus.i_valid[idx[L-1:0]]) begin
                w_any    = 1'b1;
                w_winner = idx[L-1:0];
            end
        end
`ifdef ARB_MUX_STAGE_LAST_LOCK_EN
        if (r_lock == LOCK_HELD) begin
            w_any    = bus.i_valid[r_lock_idx];
            w_winner = r_lock_idx;
        end
`endif
    end

    always_comb begin
        bus.i_ready = '0;
        if (w_xfer) bus.i_ready[w_winner] = 1'b1;
    end

    mux #(.N(N), .W(W)) u_mux (
        .d (bus.i_data),
        .s (w_winner),
        .y (w_mux_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_last     <= 1'b0;
            r_grant    <= '0;
            r_ptr      <= '0;
`ifdef ARB_MUX_STAGE_LAST_LOCK_EN
            r_lock     <= LOCK_OPEN;
            r_lock_idx <= '0;
`endif
        end else if (w_load) begin
            r_valid <= w_any;
            if (w_any) begin
                r_data  <= w_mux_y;
                r_last  <= bus.i_last[w_winner];
                r_grant <= w_winner;
`ifdef ARB_MUX_STAGE_LAST_LOCK_EN
                // The pointer stays frozen mid-packet and only advances on the closing beat.
                if (bus.i_last[w_winner]) begin
                    r_lock <= LOCK_OPEN;
                    r_ptr  <= L'(wrap_inc(int'(w_winner), N));
                end else begin
                    r_lock     <= LOCK_HELD;
                    r_lock_idx <= w_winner;
                end
`else
                r_ptr <= L'(wrap_inc(int'(w_winner), N));
`endif
            end
        end
    end

    assign bus.o_valid = r_valid;
    assign bus.o_data  = r_data;
    assign bus.o_last  = r_last;
    assign bus.o_grant = r_grant;

endmodule

// File: tb/tb_arb_mux_stage.sv
// Directed self-checking bench for arb_mux_stage (N=6, W=32).
// Packet expectations follow ARB_MUX_STAGE_LAST_LOCK_EN when it is defined.
module tb_arb_mux_stage;
    localparam int N = 6;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [N-1:0] expReady [4];
    logic [31:0]  expGrant [4];
    logic [31:0]  expData  [4];
    logic [31:0]  expLast  [4];

    arb_mux_stage_if #(.N(N), .W(W)) bus ();

    arb_mux_stage #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] valid, input logic [N-1:0] last, input logic oready);
        bus.i_valid = valid;
        bus.i_last  = last;
        bus.o_ready = oready;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int beat;
        logic [N-1:0] lastVec;

`ifdef ARB_MUX_STAGE_LAST_LOCK_EN
        expReady = '{6'b000010, 6'b000010, 6'b000010, 6'b000001};
        expGrant = '{32'd1, 32'd1, 32'd1, 32'd0};
        expData  = '{32'hB1, 32'hB2, 32'hB3, 32'hD0};
        expLast  = '{32'd0, 32'd0, 32'd1, 32'd1};
`else
        expReady = '{6'b000010, 6'b000001, 6'b000010, 6'b000001};
        expGrant = '{32'd1, 32'd0, 32'd1, 32'd0};
        expData  = '{32'hB1, 32'hD0, 32'hB2, 32'hD0};
        expLast  = '{32'd0, 32'd1, 32'd0, 32'd1};
`endif

        rst_n = 1'b0;
        for (int i = 0; i < N; i++) bus.i_data[i] = 32'(32'hD0 + i);
        applyStimulus(6'b111111, 6'b111111, 1'b1);
        checkOutput("rst_valid", 32'(bus.o_valid), 32'd0);
        checkOutput("rst_ready", 32'(bus.i_ready), 32'd0);
        checkOutput("rst_data",  bus.o_data,       32'd0);
        checkOutput("rst_grant", 32'(bus.o_grant), 32'd0);
        checkOutput("rst_last",  32'(bus.o_last),  32'd0);
        tick();
        tick();
        checkOutput("rst_valid_clk", 32'(bus.o_valid), 32'd0);
        checkOutput("rst_ready_clk", 32'(bus.i_ready), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        // Round robin with every input valid: grants 0..5 wrapping, then up to ptr=3.
        for (int k = 0; k < 15; k++) begin
            checkOutput("rr_ready", 32'(bus.i_ready), 32'(1 << (k % 6)));
            tick();
            checkOutput("rr_grant", 32'(bus.o_grant), 32'(k % 6));
            checkOutput("rr_data",  bus.o_data,       32'(32'hD0 + (k % 6)));
            checkOutput("rr_valid", 32'(bus.o_valid), 32'd1);
            checkOutput("rr_last",  32'(bus.o_last),  32'd1);
        end

        applyStimulus(6'b100100, 6'b111111, 1'b1);
        checkOutput("sparse_ready5", 32'(bus.i_ready), 32'b100000);
        tick();
        checkOutput("sparse_grant5", 32'(bus.o_grant), 32'd5);
        checkOutput("sparse_data5",  bus.o_data,       32'hD5);
        checkOutput("sparse_ready2", 32'(bus.i_ready), 32'b000100);
        tick();
        checkOutput("sparse_grant2", 32'(bus.o_grant), 32'd2);
        checkOutput("sparse_data2",  bus.o_data,       32'hD2);

        applyStimulus(6'b111111, 6'b111111, 1'b0);
        for (int k = 0; k < 3; k++) begin
            checkOutput("hold_ready", 32'(bus.i_ready), 32'd0);
            tick();
            checkOutput("hold_valid", 32'(bus.o_valid), 32'd1);
            checkOutput("hold_grant", 32'(bus.o_grant), 32'd2);
            checkOutput("hold_data",  bus.o_data,       32'hD2);
            checkOutput("hold_last",  32'(bus.o_last),  32'd1);
        end
        applyStimulus(6'b111111, 6'b111111, 1'b1);
        checkOutput("drain_ready", 32'(bus.i_ready), 32'b001000);
        tick();
        checkOutput("drain_grant", 32'(bus.o_grant), 32'd3);
        checkOutput("drain_data",  bus.o_data,       32'hD3);

        applyStimulus(6'b000000, 6'b111111, 1'b1);
        checkOutput("idle_ready", 32'(bus.i_ready), 32'd0);
        tick();
        checkOutput("idle_valid", 32'(bus.o_valid), 32'd0);
        checkOutput("idle_grant", 32'(bus.o_grant), 32'd3);
        checkOutput("idle_data",  bus.o_data,       32'hD3);

        // Input 1 sends a 3-beat packet while input 0 competes.
        beat = 1;
        for (int c = 0; c < 4; c++) begin
            bus.i_data[1] = 32'(32'hB0 + beat);
            lastVec = (beat == 3) ? 6'b111111 : 6'b111101;
            applyStimulus((c == 0) ? 6'b000010 : 6'b000011, lastVec, 1'b1);
            checkOutput("pkt_ready", 32'(bus.i_ready), 32'(expReady[c]));
            if (bus.i_ready[1]) beat++;
            tick();
            checkOutput("pkt_grant", 32'(bus.o_grant), expGrant[c]);
            checkOutput("pkt_data",  bus.o_data,       expData[c]);
            checkOutput("pkt_last",  32'(bus.o_last),  expLast[c]);
        end

        applyStimulus(6'b001000, 6'b000000, 1'b1);
        checkOutput("mid_ready", 32'(bus.i_ready), 32'b001000);
        tick();
        checkOutput("mid_grant", 32'(bus.o_grant), 32'd3);
        checkOutput("mid_valid", 32'(bus.o_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", 32'(bus.o_valid), 32'd0);
        checkOutput("arst_grant", 32'(bus.o_grant), 32'd0);
        checkOutput("arst_data",  bus.o_data,       32'd0);
        checkOutput("arst_ready", 32'(bus.i_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(6'b111111, 6'b111111, 1'b1);
        checkOutput("restart_ready", 32'(bus.i_ready), 32'b000001);
        tick();
        checkOutput("restart_grant", 32'(bus.o_grant), 32'd0);
        checkOutput("restart_data",  bus.o_data,       32'hD0);
        checkOutput("restart_valid", 32'(bus.o_valid), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arb_mux_stage.md
# arb_mux_stage

Registered N:1 round-robin arbitration stage for NoC switch output ports. It picks one valid input per cycle, steers that input through the generic `mux` using a computed select, and captures the result in an output register with a valid/ready handshake. It sits directly upstream of a switch output link, feeding the output channel from N competing input queues.

## Interface
- N, 6, number of competing inputs (2..16, need not be a power of 2)
- W, DEFAULT_D_W, payload width of each input and the output
- L, $clog2(N), select/grant index width (localparam)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_valid  in  N  per-input valid
- i_ready  out  N  per-input ready, at most one bit high per cycle
- i_data  in  [N-1:0][W-1:0]  per-input payload
- i_last  in  N  per-input end-of-packet flag
- o_valid  out  1  output register holds a beat
- o_ready  in  1  downstream accepts the beat
- o_data  out  W  registered payload
- o_last  out  1  registered end-of-packet flag
- o_grant  out  L  index of the input that supplied the current o_data

## Operation
- Round-robin pointer `ptr` (L bits, 0..N-1). The winner is the first index with i_valid set, scanning ptr, ptr+1, ... with wrap from N-1 to 0 (explicit compare, no power-of-2 masking).
- `load = ~o_valid | o_ready`. When load is high and some i_valid is set, assert i_ready[winner], register i_data[winner]/i_last[winner] into o_data/o_last, set o_grant=winner and o_valid=1.
- When load is high and no input is valid, set o_valid=0. o_data/o_last/o_grant hold their values.
- When load is low, the output register and ptr hold and all i_ready are 0.
- On each transfer, ptr <= winner+1, or 0 when winner == N-1.
- i_data is steered by one `mux` instance with s = winner. Its output feeds only the o_data register.
- i_ready is purely combinational from i_valid, ptr, o_valid, o_ready and the lock state. It must not depend on o_data.
- Reset values: o_valid=0, o_data=0, o_last=0, o_grant=0, ptr=0, lock cleared. A reset during operation drops any held beat and any partially forwarded packet.

## Timing
- Latency is one cycle: an input beat accepted in cycle t appears on o_data in cycle t+1.
- Full throughput: one beat per cycle while o_ready=1 and any input is valid.
- Output holds stable while o_valid=1 and o_ready=0, as AXI-stream requires.
- Simultaneous o_ready and a new winner: the old beat drains and the new beat loads in the same cycle.

## Configuration
- ARB_MUX_STAGE_LAST_LOCK_EN defined: packet lock is enabled.
  - Once an input wins with i_last=0, the grant is locked to that index and ptr is frozen.
  - Other inputs stay unready until a beat with i_last=1 transfers from the locked input.
  - The lock then clears and ptr <= locked+1 (with wrap).
  - While locked, a cycle where the locked input is not valid produces no transfer. No other input is served.
- ARB_MUX_STAGE_LAST_LOCK_EN undefined: arbitration is per beat. i_last only passes through to o_last.

## Structure
- W defaults to DEFAULT_D_W from common_pkg. Add a shared `ARB_MAX_N = 16` constant to common_pkg for the parameter range check.
- Sub-module: the existing generic `mux` (N, W) performs the data steering. The winner-find logic stays in this module.
- Elaboration-time assertion: 2 <= N <= ARB_MAX_N.

## Test plan
- Reset with all i_valid=1 -> during reset o_valid=0, i_ready=0; first cycle after reset i_ready=6'b000001, next cycle o_grant=0 and o_data=i_data[0].
- N=6, all inputs valid, o_ready=1 for 12 cycles -> o_grant sequence 0,1,2,3,4,5,0,1,2,3,4,5 (wrap at 5), one beat per cycle.
- Only inputs 2 and 5 valid, ptr=3 -> input 5 wins; the next winner is 2 (wrap via 0).
- Output held with o_ready=0 for 3 cycles -> o_data/o_grant/o_last stable, i_ready=0; on o_ready=1 the next beat loads in the same cycle.
- With LAST_LOCK_EN: input 1 sends a 3-beat packet (last on beat 3) while input 0 is valid -> o_grant=1,1,1 then 0. Without LAST_LOCK_EN -> beats interleave 1,0,1,0,...
- rst_n asserted while o_valid=1 mid-packet -> o_valid=0 and the lock clears immediately (async); after release, arbitration restarts from ptr=0.
